// File: rtl/wb_port_arbiter_if.sv
// Writeback request bundle from three requesters plus the two registered regfile write ports.
interface wb_port_arbiter_if #(
    parameter int SEQ_W = 6,
    parameter int CNT_W = 16
);
    logic [2:0]         req_valid;
    logic [14:0]        req_rd;
    logic [95:0]        req_data;
    logic [3*SEQ_W-1:0] req_seq;
    logic [2:0]         req_ready;
    logic [4:0]         rd1;
    logic [4:0]         rd2;
    logic [31:0]        dist1;
    logic [31:0]        dist2;
    logic               reg_write1;
    logic               reg_write2;
    logic [CNT_W-1:0]   merge_cnt;

    modport master (
        output req_valid, req_rd, req_data, req_seq,
        input  req_ready, rd1, rd2, dist1, dist2, reg_write1, reg_write2, merge_cnt
    );

    modport slave (
        input  req_valid, req_rd, req_data, req_seq,
        output req_ready, rd1, rd2, dist1, dist2, reg_write1, reg_write2, merge_cnt
    );
endinterface

// File: rtl/wb_port_arbiter.sv
// Grants the two oldest nonzero-rd writebacks onto regfile ports 1/2; outputs registered, 1 cycle after accept.
// req_ready is combinational; the youngest of three candidates waits, rd=x0 requests are always accepted.
module wb_port_arbiter #(
    parameter int SEQ_W = 6,
    parameter int CNT_W = 16
) (
    input logic              CLK,
    input logic              RST,
    wb_port_arbiter_if.slave wb
);
    logic [4:0]       rd_w  [3];
    logic [31:0]      dat_w [3];
    logic [SEQ_W-1:0] seq_w [3];
    logic [1:0]       rank  [3];
    logic [2:0]       cand;
    logic [2:0]       grant;
    logic [1:0]       n_grant;
    logic [1:0]       o_idx;
    logic [1:0]       y_idx;
    logic [1:0]       p1_idx;

    logic [4:0]       rd1_q, rd1_d, rd2_q, rd2_d;
    logic [31:0]      dist1_q, dist1_d, dist2_q, dist2_d;
    logic             we1_q, we1_d, we2_q, we2_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Wrapping age compare: a is older when b lies in the half-window ahead of it.
    function automatic logic is_older(input logic [SEQ_W-1:0] a,
                                      input logic [SEQ_W-1:0] b,
                                      input logic a_lower_idx);
        logic [SEQ_W-1:0] diff;
        diff = b - a;
        return (a == b) ? a_lower_idx : !diff[SEQ_W-1];
    endfunction

    always_comb begin
        for (int i = 0; i < 3; i++) begin
            rd_w[i]  = wb.req_rd[5*i +: 5];
            dat_w[i] = wb.req_data[32*i +: 32];
            seq_w[i] = wb.req_seq[SEQ_W*i +: SEQ_W];
            cand[i]  = wb.req_valid[i] && (rd_w[i] != 5'd0);
        end
    end

    always_comb begin
        n_grant = 2'd0;
        o_idx   = 2'd0;
        y_idx   = 2'd0;
        grant   = 3'b000;
        for (int i = 0; i < 3; i++) begin
            rank[i] = 2'd0;
            for (int j = 0; j < 3; j++) begin
                if (j != i && cand[j] && is_older(seq_w[j], seq_w[i], j < i))
                    rank[i] = rank[i] + 2'd1;
            end
            grant[i] = cand[i] && (rank[i] < 2'd2);
            n_grant  = n_grant + {1'b0, grant[i]};
            if (grant[i] && rank[i] == 2'd0) o_idx = 2'(i);
            if (grant[i] && rank[i] == 2'd1) y_idx = 2'(i);
        end
        p1_idx = (n_grant == 2'd2) ? y_idx : o_idx;
    end

    always_comb begin
        for (int i = 0; i < 3; i++)
            wb.req_ready[i] = !RST && wb.req_valid[i] && (rd_w[i] == 5'd0 || grant[i]);
    end

    always_comb begin
        rd1_d   = rd1_q;
        dist1_d = dist1_q;
        rd2_d   = rd2_q;
        dist2_d = dist2_q;
        we1_d   = (n_grant != 2'd0);
        we2_d   = (n_grant == 2'd2);
        cnt_d   = cnt_q;
        if (we1_d) begin
            rd1_d   = rd_w[p1_idx];
            dist1_d = dat_w[p1_idx];
        end
        if (we2_d) begin
            rd2_d   = rd_w[o_idx];
            dist2_d = dat_w[o_idx];
            // Regfile drops port 2 on equal rd, so the younger value on port 1 wins.
            if (rd_w[o_idx] == rd_w[y_idx] && cnt_q != {CNT_W{1'b1}})
                cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            rd1_q   <= '0;
            rd2_q   <= '0;
            dist1_q <= '0;
            dist2_q <= '0;
            we1_q   <= 1'b0;
            we2_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            rd1_q   <= rd1_d;
            rd2_q   <= rd2_d;
            dist1_q <= dist1_d;
            dist2_q <= dist2_d;
            we1_q   <= we1_d;
            we2_q   <= we2_d;
            cnt_q   <= cnt_d;
        end
    end

    assign wb.rd1        = rd1_q;
    assign wb.rd2        = rd2_q;
    assign wb.dist1      = dist1_q;
    assign wb.dist2      = dist2_q;
    assign wb.reg_write1 = we1_q;
    assign wb.reg_write2 = we2_q;
    assign wb.merge_cnt  = cnt_q;
endmodule

// File: tb/tb_wb_port_arbiter.sv
// Randomized and directed bench for wb_port_arbiter against a sorted-queue age model.
module tb_wb_port_arbiter;
    localparam int SEQ_W = 4;
    localparam int CNT_W = 10;
    localparam int M     = 1 << SEQ_W;
    localparam int OW    = 76 + CNT_W;
    localparam int CMAX  = (1 << CNT_W) - 1;

    logic CLK = 1'b0;
    logic RST = 1'b0;

    wb_port_arbiter_if #(.SEQ_W(SEQ_W), .CNT_W(CNT_W)) bus ();
    wb_port_arbiter #(.SEQ_W(SEQ_W), .CNT_W(CNT_W)) dut (.CLK(CLK), .RST(RST), .wb(bus));

    always #5 CLK = ~CLK;

    int checks = 0;
    int passed = 0;

    logic [2:0]  v;
    logic [4:0]  rdv [3];
    logic [31:0] dv  [3];
    int          sv  [3];

    logic [2:0]  e_ready;
    logic        e_we1, e_we2;
    logic [4:0]  e_rd1, e_rd2;
    logic [31:0] e_d1, e_d2;
    int          e_cnt;

    logic [31:0] rf [32];

    always @(posedge CLK) begin
        if (bus.reg_write2 && !(bus.reg_write1 && bus.rd1 == bus.rd2)) rf[bus.rd2] <= bus.dist2;
        if (bus.reg_write1) rf[bus.rd1] <= bus.dist1;
    end

    task automatic drive();
        bus.req_valid = v;
        for (int i = 0; i < 3; i++) begin
            bus.req_rd[5*i +: 5]           = rdv[i];
            bus.req_data[32*i +: 32]       = dv[i];
            bus.req_seq[SEQ_W*i +: SEQ_W]  = SEQ_W'(sv[i]);
        end
    endtask

    function automatic bit older(int ia, int ib);
        int a = sv[ia] % M;
        int b = sv[ib] % M;
        if (a == b) return ia < ib;
        return ((b - a + M) % M) < (M / 2);
    endfunction

    // Model: order candidates oldest-first, grant the first two, predict next-cycle ports.
    task automatic model_eval();
        int q[$];
        if (RST) begin
            e_ready = 3'b000;
            e_we1 = 0; e_we2 = 0; e_rd1 = 0; e_rd2 = 0; e_d1 = 0; e_d2 = 0; e_cnt = 0;
            return;
        end
        for (int i = 0; i < 3; i++) begin
            if (v[i] && rdv[i] != 0) begin
                int p = q.size();
                for (int k = q.size() - 1; k >= 0; k--)
                    if (older(i, q[k])) p = k;
                q.insert(p, i);
            end
        end
        e_ready = 3'b000;
        for (int i = 0; i < 3; i++) if (v[i] && rdv[i] == 0) e_ready[i] = 1'b1;
        for (int k = 0; k < q.size() && k < 2; k++) e_ready[q[k]] = 1'b1;
        if (q.size() >= 2) begin
            e_we1 = 1; e_rd1 = rdv[q[1]]; e_d1 = dv[q[1]];
            e_we2 = 1; e_rd2 = rdv[q[0]]; e_d2 = dv[q[0]];
            if (rdv[q[0]] == rdv[q[1]] && e_cnt < CMAX) e_cnt++;
        end else if (q.size() == 1) begin
            e_we1 = 1; e_rd1 = rdv[q[0]]; e_d1 = dv[q[0]];
            e_we2 = 0;
        end else begin
            e_we1 = 0; e_we2 = 0;
        end
    endtask

    task automatic retire();
        for (int i = 0; i < 3; i++) if (e_ready[i]) v[i] = 1'b0;
    endtask

    function automatic logic [OW-1:0] obs();
        return {bus.reg_write1, bus.rd1, bus.dist1, bus.reg_write2, bus.rd2, bus.dist2, bus.merge_cnt};
    endfunction

    function automatic logic [OW-1:0] expv();
        return {e_we1, e_rd1, e_d1, e_we2, e_rd2, e_d2, CNT_W'(e_cnt)};
    endfunction

    task automatic set_req(int i, bit val, int rd, int data, int seq);
        v[i] = val; rdv[i] = 5'(rd); dv[i] = 32'(data); sv[i] = seq;
    endtask

    task automatic test_reset();
        set_req(0, 1, 1, 32'h10, 0);
        set_req(1, 1, 2, 32'h20, 1);
        set_req(2, 1, 3, 32'h30, 2);
        drive();
        #1 RST = 1'b1;
        #1 model_eval();
        checks++;
        if (bus.req_ready !== 3'b000) $display("FAIL reset_ready got %b want 000", bus.req_ready);
        else passed++;
        checks++;
        if (obs() !== {OW{1'b0}}) $display("FAIL reset_outputs got %h want 0", obs());
        else passed++;
        @(posedge CLK); #1;
        checks++;
        if (obs() !== expv()) $display("FAIL reset_hold got %h want %h", obs(), expv());
        else passed++;
        @(negedge CLK);
        RST = 1'b0;
        v = 3'b000;
        drive();
        model_eval();
        @(posedge CLK); #1;
    endtask

    task automatic test_age();
        set_req(0, 1, 1, 32'hAAAA_0001, 5);
        set_req(1, 1, 2, 32'hBBBB_0002, 3);
        set_req(2, 1, 3, 32'hCCCC_0003, 4);
        for (int c = 0; c < 3; c++) begin
            drive(); model_eval();
            @(negedge CLK);
            checks++;
            if (bus.req_ready !== e_ready) $display("FAIL age_ready c%0d got %b want %b", c, bus.req_ready, e_ready);
            else passed++;
            @(posedge CLK); #1;
            checks++;
            if (obs() !== expv()) $display("FAIL age_ports c%0d got %h want %h", c, obs(), expv());
            else passed++;
            retire();
        end
    endtask

    task automatic test_merge();
        set_req(0, 1, 5, 32'h11, 7);
        set_req(1, 1, 5, 32'h22, 8);
        set_req(2, 0, 0, 0, 0);
        for (int c = 0; c < 2; c++) begin
            drive(); model_eval();
            @(negedge CLK);
            checks++;
            if (bus.req_ready !== e_ready) $display("FAIL merge_ready c%0d got %b want %b", c, bus.req_ready, e_ready);
            else passed++;
            @(posedge CLK); #1;
            checks++;
            if (obs() !== expv()) $display("FAIL merge_ports c%0d got %h want %h", c, obs(), expv());
            else passed++;
            retire();
        end
        checks++;
        if (rf[5] !== 32'h22) $display("FAIL merge_regfile got %h want 00000022", rf[5]);
        else passed++;
    endtask

    task automatic test_x0();
        set_req(0, 1, 0, 32'hDEAD_0000, 9);
        set_req(1, 1, 4, 32'h4444, 10);
        set_req(2, 1, 6, 32'h6666, 11);
        for (int c = 0; c < 2; c++) begin
            drive(); model_eval();
            @(negedge CLK);
            checks++;
            if (bus.req_ready !== e_ready) $display("FAIL x0_ready c%0d got %b want %b", c, bus.req_ready, e_ready);
            else passed++;
            @(posedge CLK); #1;
            checks++;
            if (obs() !== expv()) $display("FAIL x0_ports c%0d got %h want %h", c, obs(), expv());
            else passed++;
            retire();
        end
    endtask

    task automatic test_wrap();
        set_req(0, 1, 7, 32'h7777_000F, 15);
        set_req(1, 1, 7, 32'h7777_0001, 1);
        set_req(2, 0, 0, 0, 0);
        for (int c = 0; c < 2; c++) begin
            drive(); model_eval();
            @(negedge CLK);
            checks++;
            if (bus.req_ready !== e_ready) $display("FAIL wrap_ready c%0d got %b want %b", c, bus.req_ready, e_ready);
            else passed++;
            @(posedge CLK); #1;
            checks++;
            if (obs() !== expv()) $display("FAIL wrap_ports c%0d got %h want %h", c, obs(), expv());
            else passed++;
            retire();
        end
        checks++;
        if (rf[7] !== 32'h7777_0001) $display("FAIL wrap_regfile got %h want 77770001", rf[7]);
        else passed++;
    endtask

    task automatic test_random();
        int base = 0;
        v = 3'b000;
        for (int blk = 0; blk < 15; blk++) begin
            for (int c = 0; c < 22; c++) begin
                for (int i = 0; i < 3; i++) begin
                    if (!v[i] && c < 20 && $urandom_range(0, 3) != 0)
                        set_req(i, 1, $urandom_range(0, 7), $urandom, (base + $urandom_range(0, 6)) % M);
                end
                drive(); model_eval();
                @(negedge CLK);
                checks++;
                if (bus.req_ready !== e_ready) $display("FAIL rand_ready b%0d c%0d got %b want %b", blk, c, bus.req_ready, e_ready);
                else passed++;
                @(posedge CLK); #1;
                checks++;
                if (obs() !== expv()) $display("FAIL rand_ports b%0d c%0d got %h want %h", blk, c, obs(), expv());
                else passed++;
                retire();
            end
            base = (base + 5) % M;
        end
    endtask

    task automatic test_saturate_and_reset();
        set_req(0, 1, 9, 32'h9000, 0);
        set_req(1, 1, 9, 32'h9001, 1);
        set_req(2, 0, 0, 0, 0);
        drive();
        for (int c = 0; c < CMAX + 4; c++) begin
            model_eval();
            @(posedge CLK);
        end
        #1;
        checks++;
        if (obs() !== expv()) $display("FAIL sat_ports got %h want %h", obs(), expv());
        else passed++;
        checks++;
        if (bus.merge_cnt !== {CNT_W{1'b1}}) $display("FAIL sat_count got %h want all ones", bus.merge_cnt);
        else passed++;
        RST = 1'b1;
        #1 model_eval();
        checks++;
        if (obs() !== expv()) $display("FAIL midreset_clear got %h want %h", obs(), expv());
        else passed++;
        checks++;
        if (bus.req_ready !== 3'b000) $display("FAIL midreset_ready got %b want 000", bus.req_ready);
        else passed++;
        @(posedge CLK); #1;
        checks++;
        if ({bus.reg_write1, bus.reg_write2} !== 2'b00) $display("FAIL midreset_we got %b want 00", {bus.reg_write1, bus.reg_write2});
        else passed++;
        @(negedge CLK);
        RST = 1'b0;
        v = 3'b000;
        drive();
    endtask

    initial begin
        test_reset();
        test_age();
        test_merge();
        test_x0();
        test_wrap();
        test_random();
        test_saturate_and_reset();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
